// File: rtl/capture_word_fifo.sv
// Word capture stage: classifies input-stage words by counter transitions and
// buffers them, frame-terminated, in a show-ahead FIFO with a valid/ready read port.
module capture_word_fifo #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              LLC,
  input  logic              rst_n,
  input  logic [31:0]       data_in,
  input  logic [20:0]       counter_in,
  output logic [31:0]       out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_trunc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [7:0]        frames_dropped
);

  typedef enum logic [1:0] {IDLE, PASS, TRUNC, SKIP} state_t;

  localparam logic [ADDR_W:0] PAY_LIM = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] SOF_LIM = (ADDR_W+1)'(DEPTH - 2);

  state_t              state, state_nx;
  logic [20:0]         cnt_q;
  logic [34:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     level_q, level_eff;
  logic [34:0]         head, push_entry;
  logic                strobe, is_eof, is_sof;
  logic                push, pop, room_pay, room_sof, ovf_set, drop_inc;

  assign strobe = (counter_in != cnt_q);
  assign is_eof = (counter_in == 21'd0) && (cnt_q != 21'd0);
  assign is_sof = (counter_in == 21'd1) && (cnt_q == 21'd0);

  assign pop       = out_valid & out_ready;
  // A slot freed by this cycle's pop is usable by this cycle's push.
  assign level_eff = level_q - {{ADDR_W{1'b0}}, pop};
  assign room_pay  = level_eff < PAY_LIM;
  assign room_sof  = level_eff < SOF_LIM;

  always_comb begin
    state_nx   = state;
    push       = 1'b0;
    push_entry = '0;
    ovf_set    = 1'b0;
    drop_inc   = 1'b0;
    if (strobe) begin
      unique case (state)
        IDLE: if (is_sof) begin
          if (room_sof) begin
            push       = 1'b1;
            push_entry = {3'b010, data_in};
            state_nx   = PASS;
          end else begin
            ovf_set  = 1'b1;
            drop_inc = 1'b1;
            state_nx = SKIP;
          end
        end
        PASS: if (is_eof) begin
          push       = 1'b1;
          push_entry = {3'b001, data_in};
          state_nx   = IDLE;
        end else if (is_sof) begin
          // Close the open frame with a synthetic end code; the new SOF is dropped.
          push       = 1'b1;
          push_entry = {3'b101, 32'h0000_0055};
          drop_inc   = 1'b1;
          state_nx   = IDLE;
        end else if (room_pay) begin
          push       = 1'b1;
          push_entry = {3'b000, data_in};
        end else begin
          ovf_set  = 1'b1;
          drop_inc = 1'b1;
          state_nx = TRUNC;
        end
        TRUNC: if (is_eof) begin
          push       = 1'b1;
          push_entry = {3'b101, data_in};
          state_nx   = IDLE;
        end
        SKIP: if (is_eof) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge LLC) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_q        <= '0;
      overflow       <= 1'b0;
      frames_dropped <= '0;
    end else begin
      cnt_q <= counter_in;
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (drop_inc && frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 1'b1;
    end
  end

  always_ff @(posedge LLC) begin
    if (rst_n && push) mem[wr_ptr] <= push_entry;
  end

  assign head      = mem[rd_ptr];
  assign level     = level_q;
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? head[31:0] : '0;
  assign out_eof   = out_valid & head[32];
  assign out_sof   = out_valid & head[33];
  assign out_trunc = out_valid & head[34];

endmodule

// File: doc/capture_word_fifo.md
Name: capture_word_fifo

Overview:
- Sits directly downstream of the ADV pixel input stage, in the LLC clock domain.
- Consumes that stage's registered 32-bit word and 21-bit word counter. A new word is detected by a counter change.
- Each word is classified as start-of-frame, end-of-frame or payload, then buffered in a show-ahead FIFO with a valid/ready read port for the transport logic.
- Guarantees that every buffered frame is terminated. On overflow it truncates the frame cleanly and counts the drop.

Parameters:
- DEPTH, 512, FIFO depth in 32-bit words; power of two, at least 4.
- ADDR_W, 9, log2(DEPTH).

Ports:
- LLC  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- data_in  in  32  word from input stage.
- counter_in  in  21  word counter from input stage.
- out_data  out  32  FIFO head word.
- out_sof  out  1  head word is the frame start code.
- out_eof  out  1  head word is the frame end code.
- out_trunc  out  1  head is an end word of a truncated frame.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  reader accepts head this cycle.
- level  out  ADDR_W+1  words currently stored.
- overflow  out  1  sticky; a word was lost.
- clr_ovf  in  1  clears overflow.
- frames_dropped  out  8  saturating count of truncated or skipped frames.

Behaviour:
- Reset (rst_n low at an LLC edge):
  - cnt_q=0; FIFO empty; level=0.
  - out_valid=0; out_data, out_sof, out_eof, out_trunc all 0.
  - overflow=0; frames_dropped=0; state=IDLE.
  - Reset mid-frame discards all stored words. The next accepted frame starts at the next SOF.
- Change detect:
  - cnt_q <= counter_in every cycle.
  - strobe = (counter_in != cnt_q). At most one word per cycle; a jump larger than 1 counts as one word.
- Classification, only when strobe is 1:
  - EOF: counter_in==0 and cnt_q!=0.
  - SOF: counter_in==1 and cnt_q==0.
  - Otherwise PAY.
  - The word pushed is data_in in the strobe cycle.
- FIFO:
  - Entry is {trunc,sof,eof,data}, 35 bits.
  - Show-ahead: out_* reflect the head combinationally from storage. out_valid = (level!=0).
  - pop = out_valid & out_ready.
  - Push and pop in the same cycle are allowed; level is unchanged.
  - Pointers wrap modulo DEPTH.
  - level updates one cycle after push/pop. A pushed word is visible on out_* the cycle after the push.
- Room rules (pop in the same cycle counts as freeing a slot):
  - room_pay: level < DEPTH-1. One slot is always reserved for EOF.
  - room_sof: level < DEPTH-2. Keeps one PAY slot plus the EOF slot.
- State machine:
  - IDLE:
    - PAY/EOF: discard.
    - SOF with room_sof: push, go PASS.
    - SOF without room_sof: discard, frames_dropped+1, overflow=1, go SKIP.
  - PASS:
    - PAY with room_pay: push.
    - PAY without room_pay: discard, overflow=1, frames_dropped+1, go TRUNC.
    - EOF: push with eof=1 (guaranteed to fit), go IDLE.
    - SOF: push eof entry {trunc=1, data=0x00000055}, frames_dropped+1, go IDLE. That SOF is discarded.
  - TRUNC:
    - PAY/SOF: discard.
    - EOF: push with eof=1, trunc=1, go IDLE.
  - SKIP:
    - All words discarded.
    - EOF: go IDLE.
- overflow: set wins over clr_ovf in the same cycle.
- frames_dropped: saturates at 255.
- Invariant: in PASS/TRUNC at least one free slot exists, so no frame is ever left without an EOF entry.

Test Plan:
- Clean frame: counter 0→1 with data 0x0000820C, then 1→2, 2→3 with 0xBABEFACE, 3→4 with 0x11223344, then 4→0 with 0x00000055; out_ready=1.
  - Expect 5 pops in order, out_sof only on the first, out_eof on the last, out_trunc=0, overflow=0.
- Stalled counter: hold counter_in constant for 10 cycles while data_in changes → no push, level constant.
- Overflow: DEPTH=8, out_ready=0, feed SOF plus 10 PAY words then EOF.
  - Expect SOF plus 6 PAY words stored, then an EOF entry with trunc=1; level=8.
  - Expect overflow=1 and frames_dropped=1.
- Skip: FIFO at level 6 of 8, SOF arrives → SKIP; PAY and EOF discarded.
  - Next SOF after draining is accepted. frames_dropped increments.
- Simultaneous push/pop at level DEPTH-2 with out_ready=1 → PAY accepted, level unchanged, head advances by one.
- Reset mid-frame, then a new SOF → out_valid=0 after reset; only the new frame appears, overflow=0.
